fpnew_slice_out_buffer: RTL and testbench
=========================================

FPNEW_SLICE_OUT_BUFFER -- requirements
Module: fpnew_slice_out_buffer

Interface
REQ-001 SHALL have parameter Width, default 32, meaning result data width in bits.
REQ-002 SHALL have parameter Depth, default 2, meaning number of buffered entries; legal range 1..16, not restricted to powers of two.
REQ-003 SHALL have parameter TagType, default logic, meaning the opaque tag type carried with each result.
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have ports result_i (input, Width), status_i (input, 5, fpnew_pkg::status_t), extension_bit_i (input, 1) and tag_i (input, TagType); together these form one result entry from the upstream format slice.
REQ-007 SHALL have port in_valid_i  input  1  upstream entry valid.
REQ-008 SHALL have port in_ready_o  output  1  buffer can accept an entry.
REQ-009 SHALL have port flush_i  input  1  discard all buffered entries.
REQ-010 SHALL have ports result_o (output, Width), status_o (output, 5), extension_bit_o (output, 1) and tag_o (output, TagType); these present the head entry.
REQ-011 SHALL have port out_valid_o  output  1  head entry valid.
REQ-012 SHALL have port out_ready_i  input  1  downstream accepts the head entry.
REQ-013 SHALL have port fill_o  output  $clog2(Depth+1)  current number of stored entries.
REQ-014 SHALL have port busy_o  output  1  at least one entry is stored.
REQ-015 SHALL have port clear_sticky_i  input  1  clear the accumulated status flags.
REQ-016 SHALL have port sticky_status_o  output  5  accumulated status flags.

Function
REQ-017 SHALL push an entry when in_valid_i and in_ready_o are both high and flush_i is low.
REQ-018 SHALL pop the head entry when out_valid_o and out_ready_i are both high and flush_i is low.
REQ-019 SHALL drive in_ready_o = (fill_o < Depth); it SHALL have no combinational path from out_ready_i, so a full buffer refuses a push even in a pop cycle.
REQ-020 SHALL drive out_valid_o = (fill_o != 0); it SHALL have no combinational path from in_valid_i, giving a minimum latency of 1 cycle from push to out_valid_o.
REQ-021 SHALL drive result_o, status_o, extension_bit_o and tag_o from the head entry while out_valid_o is high, and all-zero while it is low.
REQ-022 SHALL keep the head outputs stable while out_valid_o is high and out_ready_i is low.
REQ-023 SHALL update fill_o by +1 on a push alone, -1 on a pop alone, and 0 on a simultaneous push and pop.
REQ-024 SHALL advance the write and read pointers from Depth-1 to 0 on wrap-around.
REQ-025 SHALL preserve FIFO order across wrap-around.
REQ-026 SHALL, when flush_i is high, set fill_o to 0 and reset both pointers to 0 at the next edge.
REQ-027 SHALL give flush_i priority over push and pop: no entry is written, none is popped, and sticky flags are not updated in a flush cycle.
REQ-028 SHALL drive busy_o = (fill_o != 0).

Reset
REQ-029 SHALL clear fill_o, both pointers and sticky_status_o to 0 asynchronously when rst_ni is low.
REQ-030 SHALL therefore hold in_ready_o at 1, and out_valid_o and busy_o at 0, during and after reset.
REQ-031 SHALL not reset the entry storage; data outputs read 0 only through the masking in REQ-021.
REQ-032 SHALL discard entries in flight when reset is asserted mid-operation; no partial pop is visible after rst_ni rises.

Configuration
REQ-033 SHALL implement sticky status accumulation only when macro FPNEW_OUTBUF_STICKY_STATUS_EN is defined.
REQ-034 SHALL, with FPNEW_OUTBUF_STICKY_STATUS_EN defined, update sticky_status_o at each pop to sticky_status_o | status_o.
REQ-035 SHALL, with FPNEW_OUTBUF_STICKY_STATUS_EN defined, clear the flags on clear_sticky_i alone, and set them to the popped status_o only when clear_sticky_i coincides with a pop.
REQ-036 SHALL, without FPNEW_OUTBUF_STICKY_STATUS_EN, tie sticky_status_o to 0, ignore clear_sticky_i, and keep the ports present.

Verification
REQ-037 SHALL cover Depth=2: push A (result 0x3F800000, status 5'b00001) then B with out_ready_i=0 -> fill_o=2, in_ready_o=0; raise out_ready_i -> A then B delivered in order, each with its status.
REQ-038 SHALL cover Depth=3: 10 entries pushed and popped continuously with out_ready_i=1 -> tags 0..9 delivered in order across pointer wrap; out_valid_o first high 1 cycle after the first push.
REQ-039 SHALL cover full buffer with simultaneous in_valid_i=1 and out_ready_i=1 -> one pop, no push, fill_o becomes Depth-1.
REQ-040 SHALL cover flush_i=1 with fill_o=2 and in_valid_i=1 -> next cycle fill_o=0, out_valid_o=0, and the pushed entry never appears.
REQ-041 SHALL cover FPNEW_OUTBUF_STICKY_STATUS_EN: pops with status 5'b10000 then 5'b00001 -> sticky_status_o=5'b10001; clear_sticky_i with a pop of 5'b00100 -> 5'b00100; without the macro -> always 0.
REQ-042 SHALL cover rst_ni low for 1 cycle mid-stream with fill_o=1 -> fill_o=0, in_ready_o=1, out_valid_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fpnew_slice_out_buffer.sv
// Result FIFO behind an FPnew format slice. The head entry is masked to zero while empty.
// Optional: define FPNEW_OUTBUF_STICKY_STATUS_EN to accumulate popped status flags.
package fpnew_pkg;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
endpackage

module fpnew_slice_out_buffer #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2,
  parameter type TagType = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [Width-1:0]           result_i,
  input  fpnew_pkg::status_t         status_i,
  input  logic                       extension_bit_i,
  input  TagType                     tag_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       flush_i,
  output logic [Width-1:0]           result_o,
  output fpnew_pkg::status_t         status_o,
  output logic                       extension_bit_o,
  output TagType                     tag_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(Depth+1)-1:0] fill_o,
  output logic                       busy_o,
  input  logic                       clear_sticky_i,
  output logic [4:0]                 sticky_status_o
);

  localparam int unsigned FillW = $clog2(Depth + 1);
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;

  typedef struct packed {
    logic [Width-1:0]   result;
    fpnew_pkg::status_t status;
    logic               ext;
    TagType             tag;
  } entry_t;

  entry_t            mem [Depth];
  entry_t            in_entry;
  entry_t            head;
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic [FillW-1:0]  fill_q;
  logic              push;
  logic              pop;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Ready and valid depend only on the stored count, never on the other side's handshake.
  assign in_ready_o  = (fill_q < FillW'(Depth));
  assign out_valid_o = (fill_q != '0);
  assign busy_o      = out_valid_o;
  assign fill_o      = fill_q;

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  always_comb begin
    in_entry        = '0;
    in_entry.result = result_i;
    in_entry.status = status_i;
    in_entry.ext    = extension_bit_i;
    in_entry.tag    = tag_i;
  end

  assign head            = out_valid_o ? mem[rd_ptr] : '0;
  assign result_o        = head.result;
  assign status_o        = head.status;
  assign extension_bit_o = head.ext;
  assign tag_o           = head.tag;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + FillW'(1);
        2'b01:   fill_q <= fill_q - FillW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Entry storage carries no reset; the head mask hides stale contents.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

`ifdef FPNEW_OUTBUF_STICKY_STATUS_EN
  logic [4:0] sticky_q;
  logic [4:0] pop_status;

  assign pop_status = head.status;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q <= '0;
    end else if (!flush_i) begin
      if (clear_sticky_i)
        sticky_q <= pop ? pop_status : 5'b0;
      else if (pop)
        sticky_q <= sticky_q | pop_status;
    end
  end

  assign sticky_status_o = sticky_q;
`else
  logic unused_clear_sticky;
  assign unused_clear_sticky = clear_sticky_i;
  assign sticky_status_o     = 5'b0;
`endif

endmodule

// File: tb/tb_fpnew_slice_out_buffer.sv
// Directed bench: Depth=2 vector table plus Depth=3 streaming, full-buffer and reset sequences.
module tb_fpnew_slice_out_buffer;

`ifdef FPNEW_OUTBUF_STICKY_STATUS_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Depth=2 instance
  logic [31:0] a_res_i, a_res_o;
  fpnew_pkg::status_t a_st_i, a_st_o;
  logic a_ext_i, a_ext_o;
  logic [3:0] a_tag_i, a_tag_o;
  logic a_iv, a_ir, a_fl, a_ov, a_or, a_busy, a_clr;
  logic [1:0] a_fill;
  logic [4:0] a_sticky;

  // Depth=3 instance
  logic [31:0] b_res_i, b_res_o;
  fpnew_pkg::status_t b_st_i, b_st_o;
  logic b_ext_i, b_ext_o;
  logic [3:0] b_tag_i, b_tag_o;
  logic b_iv, b_ir, b_fl, b_ov, b_or, b_busy, b_clr;
  logic [1:0] b_fill;
  logic [4:0] b_sticky;

  fpnew_slice_out_buffer #(.Width(32), .Depth(2), .TagType(logic [3:0])) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .result_i(a_res_i), .status_i(a_st_i), .extension_bit_i(a_ext_i), .tag_i(a_tag_i),
    .in_valid_i(a_iv), .in_ready_o(a_ir), .flush_i(a_fl),
    .result_o(a_res_o), .status_o(a_st_o), .extension_bit_o(a_ext_o), .tag_o(a_tag_o),
    .out_valid_o(a_ov), .out_ready_i(a_or), .fill_o(a_fill), .busy_o(a_busy),
    .clear_sticky_i(a_clr), .sticky_status_o(a_sticky)
  );

  fpnew_slice_out_buffer #(.Width(32), .Depth(3), .TagType(logic [3:0])) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .result_i(b_res_i), .status_i(b_st_i), .extension_bit_i(b_ext_i), .tag_i(b_tag_i),
    .in_valid_i(b_iv), .in_ready_o(b_ir), .flush_i(b_fl),
    .result_o(b_res_o), .status_o(b_st_o), .extension_bit_o(b_ext_o), .tag_o(b_tag_o),
    .out_valid_o(b_ov), .out_ready_i(b_or), .fill_o(b_fill), .busy_o(b_busy),
    .clear_sticky_i(b_clr), .sticky_status_o(b_sticky)
  );

  typedef struct {
    logic        iv;
    logic [31:0] res;
    logic [4:0]  st;
    logic [3:0]  tag;
    logic        ordy;
    logic        fl;
    logic        clr;
    logic [1:0]  fill;
    logic        irdy;
    logic        ovld;
    logic [31:0] xres;
    logic [4:0]  xst;
    logic [3:0]  xtag;
    logic [4:0]  xsk;
  } vec_t;

  vec_t vt[$];
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] res, input logic [4:0] st,
                              input logic [3:0] tag, input logic ordy, input logic fl,
                              input logic clr, input logic [1:0] fill, input logic irdy,
                              input logic ovld, input logic [31:0] xres, input logic [4:0] xst,
                              input logic [3:0] xtag, input logic [4:0] xsk);
    vec_t v;
    v.iv = iv; v.res = res; v.st = st; v.tag = tag; v.ordy = ordy; v.fl = fl; v.clr = clr;
    v.fill = fill; v.irdy = irdy; v.ovld = ovld; v.xres = xres; v.xst = xst; v.xtag = xtag;
    v.xsk = xsk;
    return v;
  endfunction

  task automatic chk_b(input string nm, input logic [1:0] fill, input logic ovld,
                       input logic [3:0] tag);
    chk({nm, ".fill"}, 32'(b_fill), 32'(fill));
    chk({nm, ".ovld"}, 32'(b_ov), 32'(ovld));
    chk({nm, ".tag"}, 32'(b_tag_o), 32'(tag));
  endtask

  initial begin
    rst_n = 1'b0;
    a_iv = 0; a_res_i = '0; a_st_i = '0; a_ext_i = 0; a_tag_i = '0; a_or = 0; a_fl = 0; a_clr = 0;
    b_iv = 0; b_res_i = '0; b_st_i = '0; b_ext_i = 0; b_tag_i = '0; b_or = 0; b_fl = 0; b_clr = 0;

    // inputs: iv res st tag ordy fl clr | expected pre-edge: fill irdy ovld res st tag sticky
    vt.push_back(mk(1, 32'h3F800000, 5'b00001, 4'd1, 0, 0, 0, 2'd0, 1, 0, 32'h0,        5'b00000, 4'd0, 5'b00000));
    vt.push_back(mk(1, 32'h40000000, 5'b10000, 4'd2, 0, 0, 0, 2'd1, 1, 1, 32'h3F800000, 5'b00001, 4'd1, 5'b00000));
    vt.push_back(mk(1, 32'h40400000, 5'b00100, 4'd3, 0, 0, 0, 2'd2, 0, 1, 32'h3F800000, 5'b00001, 4'd1, 5'b00000));
    vt.push_back(mk(0, 32'h0,        5'b00000, 4'd0, 1, 0, 0, 2'd2, 0, 1, 32'h3F800000, 5'b00001, 4'd1, 5'b00000));
    vt.push_back(mk(0, 32'h0,        5'b00000, 4'd0, 1, 0, 0, 2'd1, 1, 1, 32'h40000000, 5'b10000, 4'd2, 5'b00001));
    vt.push_back(mk(1, 32'h40400000, 5'b00100, 4'd3, 0, 0, 0, 2'd0, 1, 0, 32'h0,        5'b00000, 4'd0, 5'b10001));
    vt.push_back(mk(1, 32'h40800000, 5'b00010, 4'd4, 0, 0, 0, 2'd1, 1, 1, 32'h40400000, 5'b00100, 4'd3, 5'b10001));
    vt.push_back(mk(1, 32'h40A00000, 5'b01000, 4'd5, 1, 0, 1, 2'd2, 0, 1, 32'h40400000, 5'b00100, 4'd3, 5'b10001));
    vt.push_back(mk(0, 32'h0,        5'b00000, 4'd0, 0, 0, 0, 2'd1, 1, 1, 32'h40800000, 5'b00010, 4'd4, 5'b00100));
    vt.push_back(mk(1, 32'h40C00000, 5'b00000, 4'd6, 0, 0, 1, 2'd1, 1, 1, 32'h40800000, 5'b00010, 4'd4, 5'b00100));
    vt.push_back(mk(1, 32'h40E00000, 5'b00001, 4'd7, 1, 1, 0, 2'd2, 0, 1, 32'h40800000, 5'b00010, 4'd4, 5'b00000));
    vt.push_back(mk(1, 32'h41000000, 5'b00001, 4'd8, 0, 1, 0, 2'd0, 1, 0, 32'h0,        5'b00000, 4'd0, 5'b00000));
    vt.push_back(mk(1, 32'h41100000, 5'b00001, 4'd9, 0, 0, 0, 2'd0, 1, 0, 32'h0,        5'b00000, 4'd0, 5'b00000));
    vt.push_back(mk(0, 32'h0,        5'b00000, 4'd0, 1, 0, 0, 2'd1, 1, 1, 32'h41100000, 5'b00001, 4'd9, 5'b00000));
    vt.push_back(mk(0, 32'h0,        5'b00000, 4'd0, 0, 0, 0, 2'd0, 1, 0, 32'h0,        5'b00000, 4'd0, 5'b00001));

    #1;
    chk("rst.fill", 32'(a_fill), 32'd0);
    chk("rst.irdy", 32'(a_ir), 32'd1);
    chk("rst.ovld", 32'(a_ov), 32'd0);
    chk("rst.busy", 32'(a_busy), 32'd0);
    chk("rst.res", a_res_o, 32'd0);
    chk("rst.sticky", 32'(a_sticky), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      a_iv = vt[i].iv; a_res_i = vt[i].res; a_st_i = fpnew_pkg::status_t'(vt[i].st);
      a_tag_i = vt[i].tag; a_ext_i = vt[i].tag[0];
      a_or = vt[i].ordy; a_fl = vt[i].fl; a_clr = vt[i].clr;
      #1;
      chk($sformatf("v%0d.fill", i), 32'(a_fill), 32'(vt[i].fill));
      chk($sformatf("v%0d.irdy", i), 32'(a_ir), 32'(vt[i].irdy));
      chk($sformatf("v%0d.ovld", i), 32'(a_ov), 32'(vt[i].ovld));
      chk($sformatf("v%0d.busy", i), 32'(a_busy), 32'(vt[i].ovld));
      chk($sformatf("v%0d.res", i), a_res_o, vt[i].xres);
      chk($sformatf("v%0d.st", i), 32'(a_st_o), 32'(vt[i].xst));
      chk($sformatf("v%0d.tag", i), 32'(a_tag_o), 32'(vt[i].xtag));
      chk($sformatf("v%0d.ext", i), 32'(a_ext_o), 32'(vt[i].xtag[0]));
      chk($sformatf("v%0d.sticky", i), 32'(a_sticky), STK ? 32'(vt[i].xsk) : 32'd0);
    end
    @(negedge clk);
    a_iv = 0; a_or = 0; a_fl = 0; a_clr = 0;

    // Depth=3 continuous stream across pointer wrap
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      b_iv = (k < 10); b_tag_i = 4'(k); b_res_i = 32'h100 + 32'(k); b_or = 1;
      #1;
      if (k == 0) chk_b("s0", 2'd0, 1'b0, 4'd0);
      else begin
        chk_b($sformatf("s%0d", k), 2'd1, 1'b1, 4'(k - 1));
        chk($sformatf("s%0d.res", k), b_res_o, 32'h100 + 32'(k - 1));
      end
    end
    @(negedge clk);
    b_iv = 0; b_or = 0;
    #1;
    chk_b("s_end", 2'd0, 1'b0, 4'd0);

    // Depth=3 fill to full, then push+pop on a full buffer
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b_iv = 1; b_tag_i = 4'(10 + k); b_or = 0;
      #1;
      chk($sformatf("f%0d.fill", k), 32'(b_fill), 32'(k));
    end
    @(negedge clk);
    b_iv = 1; b_tag_i = 4'd13; b_or = 1;
    #1;
    chk_b("full", 2'd3, 1'b1, 4'd10);
    chk("full.irdy", 32'(b_ir), 32'd0);
    @(negedge clk);
    b_iv = 0;
    #1;
    chk_b("full_pp", 2'd2, 1'b1, 4'd11);
    @(negedge clk);
    #1;
    chk_b("drain1", 2'd1, 1'b1, 4'd12);
    @(negedge clk);
    #1;
    chk_b("drain2", 2'd0, 1'b0, 4'd0);
    b_or = 0;

    // Asynchronous reset mid-stream with one entry stored
    @(negedge clk);
    a_iv = 1; a_tag_i = 4'd5; a_res_i = 32'h12345678; a_st_i = fpnew_pkg::status_t'(5'b01000);
    a_or = 0;
    @(negedge clk);
    a_iv = 0;
    #1;
    chk("ar.fill_pre", 32'(a_fill), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.fill", 32'(a_fill), 32'd0);
    chk("ar.irdy", 32'(a_ir), 32'd1);
    chk("ar.ovld", 32'(a_ov), 32'd0);
    chk("ar.res", a_res_o, 32'd0);
    chk("ar.sticky", 32'(a_sticky), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    a_or = 1;
    #1;
    chk("ar.post_ovld", 32'(a_ov), 32'd0);
    @(negedge clk);
    #1;
    chk("ar.post_ovld2", 32'(a_ov), 32'd0);
    chk("ar.post_fill", 32'(a_fill), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
